// File: rtl/ma_load_store_unit_pkg.sv
// Shared definitions for the MA-stage load/store unit: RV32 width codes, FSM states
// and the request legality/alignment checks.
package ma_load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsuState_e;

    // func_3 width codes; loads and stores share the low encodings.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic isLegal(input logic isLoad, input logic [2:0] f3);
        if (isLoad) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

    function automatic logic isAligned(input logic [2:0] f3, input logic [1:0] addrLo);
        case (f3[1:0])
            2'b01:   return ~addrLo[0];
            2'b10:   return addrLo == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ma_byte_lane_align.sv
// Combinational byte-lane logic: store lane replication/byte enables and
// load byte/half extraction with sign or zero extension.
module ma_byte_lane_align
    import ma_load_store_unit_pkg::*;
(
    input  logic [1:0]  addrLo_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] storeData_i,
    input  logic [31:0] readWord_i,
    output logic [31:0] storeData_o,
    output logic [3:0]  byteEn_o,
    output logic [31:0] loadData_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = readWord_i[{addrLo_i, 3'b000} +: 8];
        halfSel = addrLo_i[1] ? readWord_i[31:16] : readWord_i[15:0];

        case (func3_i)
            F3_B:    loadData_o = {{24{byteSel[7]}}, byteSel};
            F3_H:    loadData_o = {{16{halfSel[15]}}, halfSel};
            F3_W:    loadData_o = readWord_i;
            F3_BU:   loadData_o = {24'd0, byteSel};
            F3_HU:   loadData_o = {16'd0, halfSel};
            default: loadData_o = '0;
        endcase
    end

    // Stores replicate the narrow datum into every lane; byte enables pick the real one.
    always_comb begin
        case (func3_i)
            F3_B: begin
                byteEn_o    = 4'b0001 << addrLo_i;
                storeData_o = {4{storeData_i[7:0]}};
            end
            F3_H: begin
                byteEn_o    = addrLo_i[1] ? 4'b1100 : 4'b0011;
                storeData_o = {2{storeData_i[15:0]}};
            end
            F3_W: begin
                byteEn_o    = 4'b1111;
                storeData_o = storeData_i;
            end
            default: begin
                byteEn_o    = 4'b0000;
                storeData_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/ma_load_store_unit.sv
// MA-stage engine: handshakes one load/store with a multi-cycle data memory,
// stalls the pipeline meanwhile and returns formatted load data.
module ma_load_store_unit
    import ma_load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func_3,
    input  logic [31:0] ALU_out,
    input  logic [31:0] DATA_2,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_writedata,
    output logic [3:0]  dmem_byteen,
    input  logic [31:0] dmem_readdata,
    input  logic        dmem_busywait,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        access_error
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    lsuState_e   state_q, state_d;
    logic        dmemRead_q, dmemRead_d;
    logic        dmemWrite_q, dmemWrite_d;
    logic [31:0] dmemAddr_q, dmemAddr_d;
    logic [31:0] dmemWriteData_q, dmemWriteData_d;
    logic [3:0]  dmemByteEn_q, dmemByteEn_d;
    logic [31:0] loadData_q, loadData_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]  funcLat_q, funcLat_d;
    logic [1:0]  addrLo_q, addrLo_d;
    logic        timedOut_q, timedOut_d;

    logic        reqValid;
    logic        reqAny;
    logic        timeoutHit;
    logic        stallComb;
    logic        errorComb;
    logic [31:0] storeLaneData;
    logic [3:0]  storeByteEn;
    logic [31:0] loadFormatted;
    logic [31:0] unusedStoreSideLoad;
    logic [31:0] unusedLoadSideStore;
    logic [3:0]  unusedLoadSideByteEn;

    ma_byte_lane_align uStoreAlign (
        .addrLo_i    (ALU_out[1:0]),
        .func3_i     (func_3),
        .storeData_i (DATA_2),
        .readWord_i  (32'd0),
        .storeData_o (storeLaneData),
        .byteEn_o    (storeByteEn),
        .loadData_o  (unusedStoreSideLoad)
    );

    // Load formatting uses the offset and width latched at request time.
    ma_byte_lane_align uLoadAlign (
        .addrLo_i    (addrLo_q),
        .func3_i     (funcLat_q),
        .storeData_i (32'd0),
        .readWord_i  (dmem_readdata),
        .storeData_o (unusedLoadSideStore),
        .byteEn_o    (unusedLoadSideByteEn),
        .loadData_o  (loadFormatted)
    );

    assign reqAny     = mem_read | mem_write;
    assign reqValid   = (mem_read ^ mem_write) && isLegal(mem_read, func_3)
                        && isAligned(func_3, ALU_out[1:0]);
    assign timeoutHit = (TIMEOUT_CYCLES != 0) && (int'(count_q) >= TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d         = state_q;
        dmemRead_d      = dmemRead_q;
        dmemWrite_d     = dmemWrite_q;
        dmemAddr_d      = dmemAddr_q;
        dmemWriteData_d = dmemWriteData_q;
        dmemByteEn_d    = dmemByteEn_q;
        loadData_d      = loadData_q;
        count_d         = count_q;
        funcLat_d       = funcLat_q;
        addrLo_d        = addrLo_q;
        timedOut_d      = timedOut_q;
        stallComb       = 1'b0;
        errorComb       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timedOut_d = 1'b0;
                if (reqValid) begin
                    stallComb       = 1'b1;
                    state_d         = ST_BUSY;
                    dmemRead_d      = mem_read;
                    dmemWrite_d     = mem_write;
                    dmemAddr_d      = {ALU_out[31:2], 2'b00};
                    dmemWriteData_d = storeLaneData;
                    dmemByteEn_d    = storeByteEn;
                    funcLat_d       = func_3;
                    addrLo_d        = ALU_out[1:0];
                    count_d         = '0;
                end else if (reqAny) begin
                    errorComb = 1'b1;
                end
            end
            ST_BUSY: begin
                stallComb = 1'b1;
                if (!dmem_busywait) begin
                    if (dmemRead_q) begin
                        loadData_d = loadFormatted;
                    end
                    dmemRead_d  = 1'b0;
                    dmemWrite_d = 1'b0;
                    count_d     = '0;
                    state_d     = ST_DONE;
                end else if (timeoutHit) begin
                    dmemRead_d  = 1'b0;
                    dmemWrite_d = 1'b0;
                    loadData_d  = '0;
                    count_d     = '0;
                    timedOut_d  = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            ST_DONE: begin
                errorComb  = timedOut_q;
                timedOut_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q         <= ST_IDLE;
            dmemRead_q      <= 1'b0;
            dmemWrite_q     <= 1'b0;
            dmemAddr_q      <= '0;
            dmemWriteData_q <= '0;
            dmemByteEn_q    <= '0;
            loadData_q      <= '0;
            count_q         <= '0;
            funcLat_q       <= '0;
            addrLo_q        <= '0;
            timedOut_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            dmemRead_q      <= dmemRead_d;
            dmemWrite_q     <= dmemWrite_d;
            dmemAddr_q      <= dmemAddr_d;
            dmemWriteData_q <= dmemWriteData_d;
            dmemByteEn_q    <= dmemByteEn_d;
            loadData_q      <= loadData_d;
            count_q         <= count_d;
            funcLat_q       <= funcLat_d;
            addrLo_q        <= addrLo_d;
            timedOut_q      <= timedOut_d;
        end
    end

    // Reset is asynchronous, so the combinational handshake outputs are masked with it too.
    assign stall          = stallComb & ~RESET;
    assign access_error   = errorComb & ~RESET;
    assign dmem_read      = dmemRead_q;
    assign dmem_write     = dmemWrite_q;
    assign dmem_addr      = dmemAddr_q;
    assign dmem_writedata = dmemWriteData_q;
    assign dmem_byteen    = dmemByteEn_q;
    assign load_data      = loadData_q;

endmodule

// File: tb/tb_ma_load_store_unit.sv
// Directed self-checking bench for ma_load_store_unit, with a second instance
// configured for a short timeout.
module tb_ma_load_store_unit;

    logic        CLK;
    logic        RESET;
    logic        mem_read, mem_write;
    logic [2:0]  func_3;
    logic [31:0] ALU_out, DATA_2;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_addr, dmem_writedata;
    logic [3:0]  dmem_byteen;
    logic [31:0] dmem_readdata;
    logic        dmem_busywait;
    logic [31:0] load_data;
    logic        stall, access_error;

    logic        toRead, toWrite, toBusywait;
    logic        toDmemRead, toDmemWrite;
    logic [31:0] toDmemAddr, unusedToWritedata;
    logic [3:0]  unusedToByteen;
    logic [31:0] toLoadData;
    logic        toStall, toAccessError;

    int assertCount = 0;
    int failCount   = 0;

    int          stallCycles;
    logic        busyRead, busyWrite, strobeHeld;
    logic [31:0] busyAddr, busyWdata;
    logic [3:0]  busyByteen;
    logic [31:0] doneLoad;
    logic        doneErr, doneRead, doneWrite;
    logic [31:0] expLoad;

    ma_load_store_unit dut (
        .CLK(CLK), .RESET(RESET),
        .mem_read(mem_read), .mem_write(mem_write), .func_3(func_3),
        .ALU_out(ALU_out), .DATA_2(DATA_2),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
        .dmem_writedata(dmem_writedata), .dmem_byteen(dmem_byteen),
        .dmem_readdata(dmem_readdata), .dmem_busywait(dmem_busywait),
        .load_data(load_data), .stall(stall), .access_error(access_error)
    );

    ma_load_store_unit #(.TIMEOUT_CYCLES(4)) dutTo (
        .CLK(CLK), .RESET(RESET),
        .mem_read(toRead), .mem_write(toWrite), .func_3(func_3),
        .ALU_out(ALU_out), .DATA_2(DATA_2),
        .dmem_read(toDmemRead), .dmem_write(toDmemWrite), .dmem_addr(toDmemAddr),
        .dmem_writedata(unusedToWritedata), .dmem_byteen(unusedToByteen),
        .dmem_readdata(dmem_readdata), .dmem_busywait(toBusywait),
        .load_data(toLoadData), .stall(toStall), .access_error(toAccessError)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Runs one access on the main DUT; memory holds busywait high for 'latency' BUSY cycles.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [31:0] rdata, input int latency);
        int busyCycles;
        @(negedge CLK);
        mem_read = rd; mem_write = wr; func_3 = f3; ALU_out = addr; DATA_2 = data;
        dmem_readdata = rdata; dmem_busywait = 1'b1;
        stallCycles = 0; busyCycles = 0; strobeHeld = 1'b1;
        #1;
        while (stall === 1'b1 && stallCycles < 300) begin
            stallCycles++;
            @(negedge CLK);
            busyCycles++;
            dmem_busywait = (busyCycles <= latency);
            #1;
            if (stall === 1'b1) begin
                if (busyCycles == 1) begin
                    busyRead = dmem_read; busyWrite = dmem_write; busyAddr = dmem_addr;
                    busyWdata = dmem_writedata; busyByteen = dmem_byteen;
                end
                if ((rd && dmem_read !== 1'b1) || (wr && dmem_write !== 1'b1)) strobeHeld = 1'b0;
            end
        end
        if (stallCycles >= 300) checkOutput("access_bound", 32'(stallCycles), 32'd0);
        doneLoad = load_data; doneErr = access_error; doneRead = dmem_read; doneWrite = dmem_write;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic applyError(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr);
        @(negedge CLK);
        mem_read = rd; mem_write = wr; func_3 = f3; ALU_out = addr; dmem_busywait = 1'b1;
        #1;
        checkOutput({tag, "_err"}, 32'(access_error), 32'd1);
        checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
        @(negedge CLK);
        #1;
        checkOutput({tag, "_rd"}, 32'(dmem_read), 32'd0);
        checkOutput({tag, "_wr"}, 32'(dmem_write), 32'd0);
        checkOutput({tag, "_load"}, load_data, expLoad);
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        int toStalls;
        RESET = 1'b1;
        mem_read = 0; mem_write = 0; func_3 = 0; ALU_out = 0; DATA_2 = 0;
        dmem_readdata = 0; dmem_busywait = 1;
        toRead = 0; toWrite = 0; toBusywait = 1;
        #12;
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_rd", 32'(dmem_read), 32'd0);
        checkOutput("rst_wr", 32'(dmem_write), 32'd0);
        checkOutput("rst_load", load_data, 32'd0);
        checkOutput("rst_byteen", 32'(dmem_byteen), 32'd0);
        checkOutput("rst_err", 32'(access_error), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        applyStimulus(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3);
        checkOutput("lw_stalls", 32'(stallCycles), 32'd5);
        checkOutput("lw_addr", busyAddr, 32'h100);
        checkOutput("lw_rd_busy", 32'(busyRead), 32'd1);
        checkOutput("lw_wr_busy", 32'(busyWrite), 32'd0);
        checkOutput("lw_held", 32'(strobeHeld), 32'd1);
        checkOutput("lw_load", doneLoad, 32'hDEADBEEF);
        checkOutput("lw_rd_done", 32'(doneRead), 32'd0);
        checkOutput("lw_err_done", 32'(doneErr), 32'd0);

        applyStimulus(1, 0, 3'b000, 32'h103, 0, 32'h80FF1234, 1);
        checkOutput("lb_stalls", 32'(stallCycles), 32'd3);
        checkOutput("lb_load", doneLoad, 32'hFFFFFF80);
        applyStimulus(1, 0, 3'b100, 32'h103, 0, 32'h80FF1234, 1);
        checkOutput("lbu_load", doneLoad, 32'h00000080);

        applyStimulus(0, 1, 3'b001, 32'h22, 32'h0000ABCD, 32'h11111111, 2);
        checkOutput("sh_stalls", 32'(stallCycles), 32'd4);
        checkOutput("sh_byteen", 32'(busyByteen), 32'hC);
        checkOutput("sh_wdata", busyWdata, 32'hABCDABCD);
        checkOutput("sh_addr", busyAddr, 32'h20);
        checkOutput("sh_held", 32'(strobeHeld), 32'd1);
        checkOutput("sh_wr_done", 32'(doneWrite), 32'd0);
        checkOutput("sh_load", doneLoad, 32'h00000080);

        applyStimulus(0, 1, 3'b000, 32'h01, 32'h00000055, 0, 0);
        checkOutput("sb_stalls", 32'(stallCycles), 32'd2);
        checkOutput("sb_byteen", 32'(busyByteen), 32'h2);
        checkOutput("sb_wdata", busyWdata, 32'h55555555);

        applyStimulus(1, 0, 3'b001, 32'h102, 0, 32'h80010000, 0);
        checkOutput("lh_load", doneLoad, 32'hFFFF8001);
        applyStimulus(1, 0, 3'b101, 32'h102, 0, 32'h80010000, 0);
        checkOutput("lhu_load", doneLoad, 32'h00008001);
        expLoad = 32'h00008001;

        applyError("lw_mis", 1, 0, 3'b010, 32'h101);
        applyError("lh_mis", 1, 0, 3'b001, 32'h103);
        applyError("ld_ill", 1, 0, 3'b011, 32'h100);
        applyError("st_ill", 0, 1, 3'b100, 32'h100);
        applyError("rd_wr", 1, 1, 3'b010, 32'h100);

        // Short-timeout instance: a good load first so the abort visibly zeroes load_data.
        @(negedge CLK);
        toRead = 1; func_3 = 3'b010; ALU_out = 32'h40; dmem_readdata = 32'h12345678; toBusywait = 0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        checkOutput("to_pre_load", toLoadData, 32'h12345678);
        toRead = 0;
        @(negedge CLK);
        toRead = 1; ALU_out = 32'h44; toBusywait = 1;
        toStalls = 0;
        #1;
        while (toStall === 1'b1 && toStalls < 50) begin
            toStalls++;
            @(negedge CLK);
            #1;
        end
        checkOutput("to_stalls", 32'(toStalls), 32'd5);
        checkOutput("to_err", 32'(toAccessError), 32'd1);
        checkOutput("to_load", toLoadData, 32'd0);
        checkOutput("to_rd", 32'(toDmemRead), 32'd0);
        checkOutput("to_addr", toDmemAddr, 32'h44);
        toRead = 0;
        @(negedge CLK);
        #1;
        checkOutput("to_err_clr", 32'(toAccessError), 32'd0);

        // Asynchronous reset in the middle of a BUSY access.
        @(negedge CLK);
        mem_read = 1; func_3 = 3'b010; ALU_out = 32'h200; dmem_busywait = 1;
        @(negedge CLK);
        #1;
        checkOutput("mid_rd_busy", 32'(dmem_read), 32'd1);
        RESET = 1'b1;
        #1;
        checkOutput("mid_rst_rd", 32'(dmem_read), 32'd0);
        checkOutput("mid_rst_load", load_data, 32'd0);
        checkOutput("mid_rst_stall", 32'(stall), 32'd0);
        @(negedge CLK);
        RESET = 1'b0; mem_read = 0;
        applyStimulus(1, 0, 3'b010, 32'h300, 0, 32'hCAFEF00D, 1);
        checkOutput("post_stalls", 32'(stallCycles), 32'd3);
        checkOutput("post_addr", busyAddr, 32'h300);
        checkOutput("post_load", doneLoad, 32'hCAFEF00D);

        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
